// File: rtl/boot_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_image_loader
// Purpose  : Packs an 8-bit boot image stream into 32-bit little-endian words,
//            writes them into the boot RAM port, then reads the written
//            region back and compares its byte sum against the load checksum.
// Revision : 1.0 - initial release
// ============================================================================
module boot_image_loader #(
    parameter int ADDR_W    = 13,
    parameter int MAX_WORDS = 8192
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       checksum
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [ADDR_W:0]   c_max_words = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0]   c_cnt_one   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one   = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       r_pack;
    logic [1:0]        r_idx;
    logic              r_eop_word;
    logic [3:0]        r_last_be;
    logic [ADDR_W:0]   r_count;
    logic [15:0]       r_sum;
    logic [15:0]       r_vsum;
    logic              r_error;
    logic [ADDR_W:0]   r_issued;
    logic              r_pend;
    logic              r_pend_last;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_cs;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic [31:0]       w_pack_next;
    logic [3:0]        w_be_next;
    logic [3:0]        w_rd_mask;
    logic [15:0]       w_rd_sum;
    logic [15:0]       w_vsum_next;

    // Pack register with the incoming byte merged into the current lane.
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[{r_idx, 3'b000} +: 8] = in_data;
        case (r_idx)
            2'd0:    w_be_next = 4'b0001;
            2'd1:    w_be_next = 4'b0011;
            2'd2:    w_be_next = 4'b0111;
            default: w_be_next = 4'b1111;
        endcase
    end

    // Byte sum of returned read data; the last word counts only its written lanes.
    always_comb begin
        w_rd_mask = r_pend_last ? r_last_be : 4'b1111;
        w_rd_sum  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (w_rd_mask[i]) begin
                w_rd_sum = w_rd_sum + {8'h00, mem_readdata[i*8 +: 8]};
            end
        end
        w_vsum_next = r_vsum + w_rd_sum;
    end

    // Load / write / verify sequencer with registered RAM-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_ptr       <= '0;
            r_pack      <= '0;
            r_idx       <= '0;
            r_eop_word  <= 1'b0;
            r_last_be   <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_vsum      <= '0;
            r_error     <= 1'b0;
            r_issued    <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_base  <= base_addr;
                        r_ptr   <= base_addr;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_error <= 1'b0;
                        r_idx   <= '0;
                        r_pack  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_count == c_max_words) begin
                            // No room left: the byte is consumed but never written.
                            r_error <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_pack <= w_pack_next;
                            r_idx  <= r_idx + 2'd1;
                            r_sum  <= r_sum + {8'h00, in_data};
                            if (r_idx == 2'd3 || in_eop) begin
                                r_state     <= S_WRITE;
                                r_mem_cs    <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_ptr;
                                r_mem_be    <= w_be_next;
                                r_mem_wdata <= w_pack_next;
                                r_eop_word  <= in_eop;
                                r_last_be   <= w_be_next;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= '0;
                    r_mem_wdata <= '0;
                    r_ptr       <= r_ptr + c_ptr_one;
                    r_count     <= r_count + c_cnt_one;
                    r_pack      <= '0;
                    r_idx       <= '0;
                    if (r_eop_word) begin
                        // First verify read is presented on the first VERIFY cycle.
                        r_state    <= S_VERIFY;
                        r_mem_cs   <= 1'b1;
                        r_mem_addr <= r_base;
                        r_issued   <= c_cnt_one;
                        r_pend     <= 1'b0;
                        r_vsum     <= '0;
                    end else begin
                        r_state    <= S_LOAD;
                        r_mem_cs   <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                S_VERIFY: begin
                    r_pend      <= r_mem_cs;
                    r_pend_last <= r_mem_cs && (r_issued == r_count);
                    if (r_mem_cs) begin
                        if (r_issued == r_count) begin
                            r_mem_cs   <= 1'b0;
                            r_mem_addr <= '0;
                        end else begin
                            r_mem_addr <= r_mem_addr + c_ptr_one;
                            r_issued   <= r_issued + c_cnt_one;
                        end
                    end
                    if (r_pend) begin
                        r_vsum <= w_vsum_next;
                        if (r_pend_last) begin
                            if (w_vsum_next != r_sum) begin
                                r_error <= 1'b1;
                            end
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = (r_state == S_LOAD);
    assign busy           = (r_state == S_LOAD) || (r_state == S_WRITE) || (r_state == S_VERIFY);
    assign done           = (r_state == S_FINISH);
    assign error          = r_error;
    assign word_count     = r_count;
    assign checksum       = r_sum;
    assign mem_address    = r_mem_addr;
    assign mem_chipselect = r_mem_cs;
    assign mem_write      = r_mem_we;
    assign mem_byteenable = r_mem_be;
    assign mem_writedata  = r_mem_wdata;
    assign mem_clken      = 1'b1;

endmodule
`default_nettype wire
